// File: rtl/mat_stream_loader.sv
// Frame loader for the matrix-multiply accelerator: forwards A then B through a
// two-entry skid buffer, frames each matrix with tlast, issues start, and waits for the result.
module mat_stream_loader #(
  parameter int DIM_LOG    = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  sel,
  output logic                  start,
  input  logic                  res_tvalid,
  input  logic                  res_tready,
  input  logic                  res_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  localparam int SIZE = 2 ** (2 * DIM_LOG);
  localparam int CW   = 2 * DIM_LOG + 1;
  localparam int OW   = 2 * DIM_LOG;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_RES
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  // in_cnt is one bit short of holding 2*SIZE, so frame completion is its own flag.
  logic          in_full_q, in_full_d;
  logic          pad_q, pad_d;
  logic          len_err_q, len_err_d;
  logic          busy_q;

  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic                  load, room, s_hs, push, pop, res_hs, in_is_last;
  logic                  push_last;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    load       = (state_q == LOAD_A) || (state_q == LOAD_B);
    room       = load && !skid_valid_q && !in_full_q;
    // While padding, the DMA is held off so the next frame is not swallowed.
    s_axis_tready = room && !pad_q;
    s_hs       = s_axis_tvalid && s_axis_tready;
    push       = s_hs || (room && pad_q);
    push_data  = pad_q ? '0 : s_axis_tdata;
    push_last  = (in_cnt_q[OW-1:0] == OW'(SIZE - 1));
    in_is_last = (in_cnt_q == CW'(2 * SIZE - 1));
    pop        = out_valid_q && m_axis_tready;
    res_hs     = res_tvalid && res_tready && res_tlast;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_full_d = in_full_q;
    pad_d     = pad_q;
    len_err_d = len_err_q;
    if (state_q == IDLE) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      in_full_d = 1'b0;
      pad_d     = 1'b0;
    end else begin
      if (push) begin
        in_cnt_d = in_cnt_q + CW'(1);
        if (in_is_last) in_full_d = 1'b1;
      end
      if (s_hs && s_axis_tlast && !in_is_last) begin
        len_err_d = 1'b1;
        pad_d     = 1'b1;
      end
      if (s_hs && !s_axis_tlast && in_is_last) len_err_d = 1'b1;
      if (pop) out_cnt_d = out_cnt_q + OW'(1);
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        out_last_d  = push && push_last;
        out_data_d  = push ? push_data : out_data_q;
      end
    end else if (push) begin
      // Output stalled: the one word already in flight lands in the skid entry.
      skid_valid_d = 1'b1;
      skid_last_d  = push_last;
      skid_data_d  = push_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (s_axis_tvalid) state_d = LOAD_A;
      LOAD_A:   if (pop && out_cnt_q == OW'(SIZE - 1)) state_d = LOAD_B;
      LOAD_B:   if (pop && out_cnt_q == OW'(SIZE - 1)) state_d = START;
      START:    state_d = WAIT_RES;
      WAIT_RES: if (res_hs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      in_full_q    <= 1'b0;
      pad_q        <= 1'b0;
      len_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      in_full_q    <= in_full_d;
      pad_q        <= pad_d;
      len_err_q    <= len_err_d;
      busy_q       <= (state_d != IDLE);
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // NOTE: data registers carry no reset; they are qualified by the valid flags, which are reset.
  always_ff @(posedge s00_axi_aclk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  always_comb begin
    m_axis_tvalid = out_valid_q;
    m_axis_tdata  = out_data_q;
    m_axis_tlast  = out_valid_q && out_last_q;
    sel           = (state_q == LOAD_B) || (state_q == START) || (state_q == WAIT_RES);
    start         = (state_q == START);
    done          = (state_q == WAIT_RES) && res_hs;
    busy          = busy_q;
    len_err       = len_err_q;
  end

endmodule
